// File: rtl/phase_pkg.sv
// ---------------------------------------------------------------------------
// phase_pkg
// Shared definitions for the five-phase core sequencing.
//   PH_F..PH_W  : bit positions of each phase inside the one-hot phase vector,
//                 shared with ir_dec, register_file and alu
//   PHASE_HALT  : phase vector value while the sequencer is halted
//   state_e     : sequencer states
//   phase_of()  : maps a state onto its one-hot phase vector
// ---------------------------------------------------------------------------
package phase_pkg;

  localparam int PH_F = 0;
  localparam int PH_R = 1;
  localparam int PH_X = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;

  localparam logic [4:0] PHASE_HALT = 5'b00000;

  typedef enum logic [2:0] {
    ST_F    = 3'd0,
    ST_R    = 3'd1,
    ST_X    = 3'd2,
    ST_M    = 3'd3,
    ST_W    = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  function automatic logic [4:0] phase_of(input state_e s);
    logic [4:0] p;
    p = PHASE_HALT;
    case (s)
      ST_F:    p[PH_F] = 1'b1;
      ST_R:    p[PH_R] = 1'b1;
      ST_X:    p[PH_X] = 1'b1;
      ST_M:    p[PH_M] = 1'b1;
      ST_W:    p[PH_W] = 1'b1;
      default: p = PHASE_HALT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/phase_ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Counts consecutive not-ready cycles of a memory access and flags the cycle
// on which the access has waited too long.
//   CLK      in  clock
//   RST      in  synchronous active-high reset
//   clr_i    in  restart counting (a new F or M access begins next cycle)
//   en_i     in  an access is in progress this cycle
//   rdy_i    in  memory ready this cycle
//   expire_o out the counter has reached WAIT_MAX and memory is still not ready
// Parameter WAIT_MAX: wait-cycle limit, 0 disables expiry.
// ---------------------------------------------------------------------------
module wait_timer
  import phase_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  input  logic rdy_i,
  output logic expire_o
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter saturates at the limit; once it is there the sequencer
  // either leaves on ready or leaves to HALT, so it never needs to wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !rdy_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Ready in the same cycle suppresses expiry.
  assign expire_o = (WAIT_MAX != 0) && en_i && !rdy_i && (cnt_q == LIMIT);

endmodule

// File: rtl/phase_ctrl.sv
// ---------------------------------------------------------------------------
// phase_ctrl
// Multi-cycle phase sequencer for the five-phase core (F,R,X,M,W). Inserts
// wait states on F and M through MEM_REQ/MEM_RDY, skips M for non-memory
// instructions, halts at instruction boundaries and counts retirements.
//   CLK      in  core clock
//   RST      in  synchronous active-high reset
//   HLT      in  halt request, honoured in W and while halted
//   IS_MEM   in  instruction uses the memory phase (valid in X)
//   MEM_RDY  in  memory ready for the current F or M access
//   STEP     in  single-step request (only with PHASE_CTRL_STEP_EN)
//   phase    out one-hot phase, all-zero while halted
//   MEM_REQ  out memory request, high in F and M
//   RETIRE   out high during W
//   HALTED   out high in HALT
//   TIMEOUT  out sticky wait-state timeout flag
//   ICOUNT   out retired-instruction count (wraps)
// Build option: define PHASE_CTRL_STEP_EN for single-step debug mode.
// ---------------------------------------------------------------------------
module phase_ctrl
  import phase_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned ICNT_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HLT,
  input  logic              IS_MEM,
  input  logic              MEM_RDY,
`ifdef PHASE_CTRL_STEP_EN
  input  logic              STEP,
`endif
  output logic [4:0]        phase,
  output logic              MEM_REQ,
  output logic              RETIRE,
  output logic              HALTED,
  output logic              TIMEOUT,
  output logic [ICNT_W-1:0] ICOUNT
);

  state_e            state_q, state_d;
  logic              timeout_q, timeout_d;
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic              timer_clr, timer_en, timer_expire;

  // A fresh wait count starts whenever an F or M access is being entered.
  assign timer_en  = (state_q == ST_F) || (state_q == ST_M);
  assign timer_clr = ((state_d == ST_F) || (state_d == ST_M)) && (state_d != state_q);

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .rdy_i    (MEM_RDY),
    .expire_o (timer_expire)
  );

  // Next-state logic. A timeout HALT is terminal until reset.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_F: begin
        if (MEM_RDY) begin
          state_d = ST_R;
        end else if (timer_expire) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end
      end
      ST_R: state_d = ST_X;
      ST_X: state_d = IS_MEM ? ST_M : ST_W;
      ST_M: begin
        if (MEM_RDY) begin
          state_d = ST_W;
        end else if (timer_expire) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end
      end
      ST_W: begin
`ifdef PHASE_CTRL_STEP_EN
        state_d = ST_HALT;
`else
        state_d = HLT ? ST_HALT : ST_F;
`endif
      end
      ST_HALT: begin
`ifdef PHASE_CTRL_STEP_EN
        if (!timeout_q && !HLT && STEP) begin
          state_d = ST_F;
        end
`else
        if (!timeout_q && !HLT) begin
          state_d = ST_F;
        end
`endif
      end
      default: state_d = ST_F;
    endcase
  end

  // Every W lasts exactly one cycle, so counting W cycles counts exits.
  assign icount_d = (state_q == ST_W) ? icount_q + ICNT_W'(1) : icount_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_F;
      timeout_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      icount_q  <= icount_d;
    end
  end

  assign phase   = phase_of(state_q);
  assign MEM_REQ = (state_q == ST_F) || (state_q == ST_M);
  assign RETIRE  = (state_q == ST_W);
  assign HALTED  = (state_q == ST_HALT);
  assign TIMEOUT = timeout_q;
  assign ICOUNT  = icount_q;

endmodule

// File: tb/tb_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phase_ctrl
// Self-checking bench for phase_ctrl. Instructions are described at a high
// level (memory or not, fetch/memory wait counts, halt length) and expanded
// into a per-cycle schedule of inputs and expected phase; the DUT is then
// compared every cycle against that schedule.
// Build option: PHASE_CTRL_STEP_EN enables the STEP port and its tests.
// ---------------------------------------------------------------------------
module tb_phase_ctrl;

  localparam int unsigned WMAX = 3;
  localparam int unsigned IW   = 4;
`ifdef PHASE_CTRL_STEP_EN
  localparam bit STEP_BUILD = 1'b1;
`else
  localparam bit STEP_BUILD = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          HLT;
  logic          IS_MEM;
  logic          MEM_RDY;
`ifdef PHASE_CTRL_STEP_EN
  logic          STEP;
`endif
  logic [4:0]    phase;
  logic          MEM_REQ;
  logic          RETIRE;
  logic          HALTED;
  logic          TIMEOUT;
  logic [IW-1:0] ICOUNT;

  typedef struct packed {
    logic       rdy;
    logic       ismem;
    logic       hlt;
    logic       step;
    logic [4:0] ph;
  } cyc_t;

  cyc_t sched[$];
  int   checks   = 0;
  int   errors   = 0;
  int   expCount = 0;

  phase_ctrl #(
    .WAIT_MAX (WMAX),
    .ICNT_W   (IW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .HLT     (HLT),
    .IS_MEM  (IS_MEM),
    .MEM_RDY (MEM_RDY),
`ifdef PHASE_CTRL_STEP_EN
    .STEP    (STEP),
`endif
    .phase   (phase),
    .MEM_REQ (MEM_REQ),
    .RETIRE  (RETIRE),
    .HALTED  (HALTED),
    .TIMEOUT (TIMEOUT),
    .ICOUNT  (ICOUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic ismem, input logic hlt,
                      input logic step, input logic [4:0] ph);
    cyc_t c;
    c.rdy = rdy; c.ismem = ismem; c.hlt = hlt; c.step = step; c.ph = ph;
    sched.push_back(c);
  endtask

  task automatic driveIn(input cyc_t c);
    MEM_RDY = c.rdy;
    IS_MEM  = c.ismem;
    HLT     = c.hlt;
`ifdef PHASE_CTRL_STEP_EN
    STEP    = c.step;
`endif
  endtask

  // Expand one instruction into cycles: F waits fw cycles then is ready,
  // M (if used) waits mw cycles, HLT/STEP are don't-care outside W/HALT.
  task automatic addInstr(input bit mem, input int fw, input int mw,
                          input bit halt, input int haltLen);
    for (int i = 0; i <= fw; i++) push(i == fw, rb(), rb(), rb(), 5'h01);
    push(rb(), rb(), rb(), rb(), 5'h02);
    push(rb(), mem, rb(), rb(), 5'h04);
    if (mem) for (int i = 0; i <= mw; i++) push(i == mw, rb(), rb(), rb(), 5'h08);
    push(rb(), rb(), halt, rb(), 5'h10);
    if (halt || STEP_BUILD)
      for (int i = 0; i < haltLen; i++)
        push(rb(), rb(), i != haltLen - 1, (i == haltLen - 1) ? 1'b1 : rb(), 5'h00);
  endtask

  task automatic runSched(input string name);
    cyc_t c;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      checks++;
      if (phase !== c.ph) begin
        errors++;
        $display("[TB] FAIL %s phase: got %h expected %h", name, phase, c.ph);
      end
      checks++;
      if ({MEM_REQ, RETIRE, HALTED, TIMEOUT} !==
          {c.ph[0] | c.ph[3], c.ph[4], c.ph == 5'h00, 1'b0}) begin
        errors++;
        $display("[TB] FAIL %s flags(req,ret,hlt,to): got %b expected %b", name,
                 {MEM_REQ, RETIRE, HALTED, TIMEOUT},
                 {c.ph[0] | c.ph[3], c.ph[4], c.ph == 5'h00, 1'b0});
      end
      checks++;
      if (ICOUNT !== IW'(expCount)) begin
        errors++;
        $display("[TB] FAIL %s icount: got %0d expected %0d", name, ICOUNT, IW'(expCount));
      end
      driveIn(c);
      @(posedge CLK); #1;
      if (c.ph == 5'h10) expCount++;
    end
  endtask

  task automatic applyReset();
    RST = 1'b1; HLT = 1'b0; IS_MEM = 1'b0; MEM_RDY = 1'b0;
`ifdef PHASE_CTRL_STEP_EN
    STEP = 1'b0;
`endif
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    expCount = 0;
    sched.delete();
  endtask

  task automatic checkHaltedTimeout(input string name);
    checks++;
    if ({phase, HALTED, TIMEOUT, MEM_REQ} !== {5'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL %s: got phase=%h halted=%b timeout=%b req=%b expected 00/1/1/0",
               name, phase, HALTED, TIMEOUT, MEM_REQ);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; HLT = 1'b1; IS_MEM = 1'b1; MEM_RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checks++;
      if ({phase, MEM_REQ, RETIRE, HALTED, TIMEOUT, ICOUNT} !==
          {5'h01, 1'b1, 1'b0, 1'b0, 1'b0, IW'(0)}) begin
        errors++;
        $display("[TB] FAIL reset_state: got phase=%h req=%b ret=%b hlt=%b to=%b cnt=%0d",
                 phase, MEM_REQ, RETIRE, HALTED, TIMEOUT, ICOUNT);
      end
    end
    applyReset();
  endtask

  task automatic test_basic_sequence();
    applyReset();
    for (int i = 0; i < 3; i++) addInstr(1'b0, 0, 0, 1'b0, 1);
    runSched("basic");
    checks++;
    if (ICOUNT !== IW'(3)) begin
      errors++;
      $display("[TB] FAIL basic_icount3: got %0d expected 3", ICOUNT);
    end
  endtask

  task automatic test_mem_wait();
    applyReset();
    addInstr(1'b1, 0, 2, 1'b0, 1);
    runSched("mem_wait");
    checks++;
    if (ICOUNT !== IW'(1)) begin
      errors++;
      $display("[TB] FAIL mem_wait_icount: got %0d expected 1", ICOUNT);
    end
  endtask

  task automatic test_halt();
    applyReset();
    addInstr(1'b0, 1, 0, 1'b1, 4);
    addInstr(1'b1, 0, 1, 1'b1, 1);
    runSched("halt");
  endtask

  task automatic test_exact_expiry();
    applyReset();
    addInstr(1'b1, WMAX, WMAX, 1'b0, 1);
    runSched("exact_expiry");
    checks++;
    if (TIMEOUT !== 1'b0 || ICOUNT !== IW'(1)) begin
      errors++;
      $display("[TB] FAIL exact_expiry_end: got timeout=%b icount=%0d expected 0/1", TIMEOUT, ICOUNT);
    end
  endtask

  task automatic test_timeout_fetch();
    applyReset();
    for (int i = 0; i <= WMAX; i++) push(1'b0, rb(), rb(), rb(), 5'h01);
    runSched("timeout_fetch");
    for (int i = 0; i < 6; i++) begin
      checkHaltedTimeout("timeout_fetch_hold");
      HLT = i[0]; MEM_RDY = rb();
`ifdef PHASE_CTRL_STEP_EN
      STEP = 1'b1;
`endif
      @(posedge CLK); #1;
    end
    applyReset();
    checks++;
    if ({phase, TIMEOUT, HALTED} !== {5'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL timeout_reset_exit: got phase=%h to=%b hlt=%b expected 01/0/0",
               phase, TIMEOUT, HALTED);
    end
  endtask

  task automatic test_timeout_mem();
    applyReset();
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h01);
    push(1'b0, 1'b0, 1'b1, 1'b0, 5'h02);
    push(1'b0, 1'b1, 1'b0, 1'b0, 5'h04);
    for (int i = 0; i <= WMAX; i++) push(1'b0, rb(), rb(), rb(), 5'h08);
    runSched("timeout_mem");
    for (int i = 0; i < 3; i++) begin
      checkHaltedTimeout("timeout_mem_hold");
      HLT = 1'b0; MEM_RDY = 1'b1;
      @(posedge CLK); #1;
    end
    checks++;
    if (ICOUNT !== IW'(0)) begin
      errors++;
      $display("[TB] FAIL timeout_mem_icount: got %0d expected 0", ICOUNT);
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    addInstr(1'b0, 0, 0, 1'b0, 1);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h01);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h02);
    push(1'b1, 1'b1, 1'b0, 1'b0, 5'h04);
    push(1'b0, 1'b0, 1'b0, 1'b0, 5'h08);
    runSched("reset_mid");
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++;
    if ({phase, RETIRE, ICOUNT} !== {5'h01, 1'b0, IW'(0)}) begin
      errors++;
      $display("[TB] FAIL reset_mid: got phase=%h ret=%b icount=%0d expected 01/0/0",
               phase, RETIRE, ICOUNT);
    end
  endtask

  task automatic test_random();
    applyReset();
    for (int n = 0; n < 40; n++)
      addInstr(rb(), int'($urandom_range(0, WMAX)), int'($urandom_range(0, WMAX)),
               $urandom_range(0, 3) == 0, int'($urandom_range(1, 3)));
    runSched("random");
  endtask

  task automatic test_step();
    applyReset();
    // first instruction halts in W even with HLT low
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h01);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h02);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h04);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h10);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
    push(1'b1, 1'b0, 1'b1, 1'b1, 5'h00);
    push(1'b1, 1'b0, 1'b0, 1'b1, 5'h00);
    // one stepped memory instruction, then halted again
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h01);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h02);
    push(1'b1, 1'b1, 1'b0, 1'b0, 5'h04);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h08);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'h10);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
    runSched("step");
    checks++;
    if (ICOUNT !== IW'(2)) begin
      errors++;
      $display("[TB] FAIL step_icount: got %0d expected 2", ICOUNT);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_mem_wait();
    test_halt();
    test_exact_expiry();
    test_timeout_fetch();
    test_timeout_mem();
    test_reset_mid();
    test_random();
    if (STEP_BUILD) test_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_ctrl.md
# phase_ctrl

Multi-cycle phase sequencer for the five-phase core. It drives the one-hot phase vector consumed by `ir_dec`, `register_file` and `alu`, and inserts wait states on the fetch and memory phases through a request/ready handshake. It skips the memory phase for non-memory instructions, halts cleanly at instruction boundaries, and counts retired instructions. It replaces the free-running phase generator as the core's sequencing authority.

## Interface
- `WAIT_MAX`, default 15: maximum number of wait cycles allowed in F or M before a timeout. 0 disables the timeout.
- `ICNT_W`, default 32: width of the retired-instruction counter.

- `CLK`  in  1  core clock; all state changes on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `HLT`  in  1  halt request; sampled only at the instruction boundary.
- `IS_MEM`  in  1  decoded "instruction uses memory phase"; valid during X.
- `MEM_RDY`  in  1  memory ready for the current F or M access.
- `phase`  out  5  one-hot phase: bit0 F, bit1 R, bit2 X, bit3 M, bit4 W. All-zero means halted.
- `MEM_REQ`  out  1  memory access request; high in F and M.
- `RETIRE`  out  1  one-cycle pulse while in W.
- `HALTED`  out  1  high in HALT state.
- `TIMEOUT`  out  1  sticky; high after a wait-state timeout.
- `ICOUNT`  out  ICNT_W  retired-instruction count.

## Operation
- States: F, R, X, M, W, HALT. `phase` is a registered one-hot encoding of the state; HALT drives 5'b00000.
- F: `MEM_REQ`=1. Stay in F until `MEM_RDY`=1, then go to R.
- R always goes to X after 1 cycle.
- X: go to M if `IS_MEM`=1, otherwise go to W.
- M: `MEM_REQ`=1. Stay in M until `MEM_RDY`=1, then go to W.
- W: `RETIRE`=1. `ICOUNT` increments on exit from W and wraps modulo 2^ICNT_W. Next state is HALT if `HLT`=1 in this cycle, otherwise F.
- HALT (entered via `HLT`): stay while `HLT`=1. Go to F on the first cycle `HLT`=0.
- `HLT` asserted in F, R, X or M has no effect until W. An in-flight instruction always completes.
- Wait counter: cleared on entry to F or M, increments each cycle in F or M with `MEM_RDY`=0.
  - If the counter equals `WAIT_MAX` (and `WAIT_MAX`≠0) and `MEM_RDY`=0, go to HALT and set `TIMEOUT`=1.
  - If `MEM_RDY`=1 in the same cycle, `MEM_RDY` wins and the normal transition occurs.
- HALT with `TIMEOUT`=1 is terminal. `HLT` is ignored; only `RST` exits.
- Reset values: state F (`phase`=5'b00001), `MEM_REQ`=1, `RETIRE`=0, `HALTED`=0, `TIMEOUT`=0, `ICOUNT`=0, wait counter=0.
- `RST` mid-instruction aborts immediately; no retire is counted.

## Timing
- Next-state logic is combinational; all outputs are registered or decoded from registered state. No combinational path from `MEM_RDY` to `phase`.
- Instruction latency with `MEM_RDY` held high:
  - non-memory instruction: 4 cycles (F,R,X,W);
  - memory instruction: 5 cycles (F,R,X,M,W).
- Each cycle of `MEM_RDY`=0 in F or M adds 1 cycle.
- Halt: with `HLT`=1 during W, the next cycle shows `phase`=0 and `HALTED`=1. After `HLT` drops, F appears on the following cycle.
- Timeout: HALT is entered on the cycle after the (`WAIT_MAX`+1)th consecutive not-ready cycle.

## Configuration
- `PHASE_CTRL_STEP_EN`: single-step debug.
  - Defined: adds input `STEP` (1 bit). Every W exits to HALT regardless of `HLT`. From a non-timeout HALT, `STEP`=1 (with `HLT`=0) runs exactly one instruction, then halts again. `HLT`=1 keeps the block in HALT even while `STEP`=1.
  - Undefined: no `STEP` port; behaviour is exactly as in Operation.

## Structure
- Shared package `phase_pkg`:
  - phase bit indices PH_F=0, PH_R=1, PH_X=2, PH_M=3, PH_W=4;
  - the state enum;
  - `PHASE_HALT`=5'b00000.
- `ir_dec`, `register_file` and `alu` use the same bit indices.
- One sub-module, `wait_timer`: clear/enable/ready inputs and an expire output, parameterised by `WAIT_MAX`.

## Test plan
- Reset release, `MEM_RDY`=1, `IS_MEM`=0 → `phase` sequence 01,02,04,10,01 (hex); `RETIRE` pulses every 4 cycles; `ICOUNT`=3 after 12 cycles.
- `IS_MEM`=1, `MEM_RDY` low for 2 cycles in M → M lasts 3 cycles, instruction takes 7 cycles, `MEM_REQ` is high throughout M.
- `HLT` raised in R → instruction completes through W, then `phase`=0 and `HALTED`=1; `HLT` drops → F on the next cycle; `ICOUNT` unchanged while halted.
- `WAIT_MAX`=3, `MEM_RDY`=0 in F → `TIMEOUT`=1 and HALT after the 4th not-ready cycle; toggling `HLT` does not exit; `RST` restores F.
- `MEM_RDY` rises on the exact expiry cycle → no timeout; normal transition to R.
- `PHASE_CTRL_STEP_EN` defined, `STEP` pulsed once → exactly one F..W sequence, one `RETIRE`, then HALT.
